// File: rtl/collision_scanner_pkg.sv
// -----------------------------------------------------------------------------
// collision_pkg
//   Shared definitions for the collision scanner slice:
//     - hit-type codes reported on o_Hit_Type
//     - scanner FSM state encoding
//     - the default goal-row wall/slot pattern
//     - the packed result record latched in the DONE state
//   Imported by collision_scanner and its interface users.
// -----------------------------------------------------------------------------
package collision_pkg;

  // Hit type codes
  localparam logic [1:0] HIT_NONE       = 2'd0;
  localparam logic [1:0] HIT_CAR        = 2'd1;
  localparam logic [1:0] HIT_WALL       = 2'd2;
  localparam logic [1:0] HIT_SUPPRESSED = 2'd3;

  // Scanner FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WALL = 2'd2,
    DONE = 2'd3
  } state_e;

  // Goal row pattern: bit c set means column c is a wall, clear means a slot
  localparam logic [19:0] DEFAULT_WALL_MASK = 20'h01B6D;

  // Result presented on the output ports from the o_Done cycle onwards
  typedef struct packed {
    logic       hit;
    logic [1:0] hit_type;
    logic [3:0] idx;
  } result_t;

endpackage

// File: rtl/collision_scanner_if.sv
// -----------------------------------------------------------------------------
// collision_scanner_if
//   Request/result bundle between the frog/car movement logic (master) and
//   the collision scanner (slave).  Clock and reset are not part of the bundle.
//
//   Master -> slave : i_Check, i_Tick, i_Frog_X, i_Frog_Y, i_Car_X, i_Car_Y
//   Slave -> master : o_Busy, o_Done, o_Hit, o_Hit_Type, o_Hit_Idx,
//                     o_In_Grace, o_Hit_Count
//   Car buses are packed, car k at [k*COORD_W +: COORD_W].
// -----------------------------------------------------------------------------
interface collision_scanner_if #(
  parameter int N_CARS  = 5,
  parameter int COORD_W = 6
);
  logic                        i_Check;
  logic                        i_Tick;
  logic [COORD_W-1:0]          i_Frog_X;
  logic [COORD_W-1:0]          i_Frog_Y;
  logic [N_CARS*COORD_W-1:0]   i_Car_X;
  logic [N_CARS*COORD_W-1:0]   i_Car_Y;
  logic                        o_Busy;
  logic                        o_Done;
  logic                        o_Hit;
  logic [1:0]                  o_Hit_Type;
  logic [3:0]                  o_Hit_Idx;
  logic                        o_In_Grace;
  logic [7:0]                  o_Hit_Count;

  modport master (
    output i_Check, i_Tick, i_Frog_X, i_Frog_Y, i_Car_X, i_Car_Y,
    input  o_Busy, o_Done, o_Hit, o_Hit_Type, o_Hit_Idx, o_In_Grace, o_Hit_Count
  );

  modport slave (
    input  i_Check, i_Tick, i_Frog_X, i_Frog_Y, i_Car_X, i_Car_Y,
    output o_Busy, o_Done, o_Hit, o_Hit_Type, o_Hit_Idx, o_In_Grace, o_Hit_Count
  );
endinterface

// File: rtl/collision_scanner_car_span_cmp.sv
// -----------------------------------------------------------------------------
// car_span_cmp
//   Combinational single-car hit comparator.  A car occupies columns
//   car_x .. car_x+CAR_LEN-1 and additionally counts MARGIN columns either
//   side.  Rows must match exactly.
//
//   Build option COLLISION_WRAP_EN:
//     undefined : plain signed comparison in COORD_W+2 bits, no wrap at the
//                 playfield edges (car at 0 never reaches frog at 63).
//     defined   : span and margin are taken modulo GRID_W, so a car near the
//                 right edge also covers the leftmost columns.
//
//   Ports:
//     frog_x_i, frog_y_i : frog position
//     car_x_i,  car_y_i  : car position
//     hit_o              : frog lies inside the car's hit window
// -----------------------------------------------------------------------------
module car_span_cmp #(
  parameter int COORD_W = 6,
  parameter int CAR_LEN = 1,
  parameter int MARGIN  = 1,
  parameter int GRID_W  = 20
) (
  input  logic [COORD_W-1:0] frog_x_i,
  input  logic [COORD_W-1:0] frog_y_i,
  input  logic [COORD_W-1:0] car_x_i,
  input  logic [COORD_W-1:0] car_y_i,
  output logic               hit_o
);

  // Two guard bits: one for sign, one so car_x+reach cannot overflow.
  localparam int DW = COORD_W + 2;
  localparam logic signed [DW-1:0] REACH_HI = DW'(CAR_LEN - 1 + MARGIN);
  localparam logic signed [DW-1:0] MARGIN_S = DW'(MARGIN);

  // The wrap arithmetic needs a nonzero modulus representable in COORD_W bits.
  if (GRID_W < 1 || GRID_W >= (1 << COORD_W)) begin : g_bad_grid
    $error("car_span_cmp: GRID_W must be in 1 .. 2**COORD_W-1");
  end

  logic y_eq;
  assign y_eq = (car_y_i == frog_y_i);

`ifdef COLLISION_WRAP_EN
  localparam logic [COORD_W-1:0]   GRID_C = COORD_W'(GRID_W);
  localparam logic signed [DW-1:0] GRID_S = DW'(GRID_W);

  logic [COORD_W-1:0]   fx_m;
  logic [COORD_W-1:0]   cx_m;
  logic signed [DW-1:0] diff;

  // diff = (frog - car) mod GRID_W, in 0 .. GRID_W-1.  Anything within the
  // forward reach hits, and so does anything within MARGIN behind the car
  // (which shows up as a diff just below GRID_W).
  always_comb begin
    fx_m = frog_x_i % GRID_C;
    cx_m = car_x_i % GRID_C;
    diff = $signed({2'b00, fx_m}) - $signed({2'b00, cx_m});
    if (diff[DW-1]) begin
      diff = diff + GRID_S;
    end
    hit_o = y_eq && ((diff <= REACH_HI) || (diff >= (GRID_S - MARGIN_S)));
  end
`else
  logic signed [DW-1:0] fx_s;
  logic signed [DW-1:0] lo_s;
  logic signed [DW-1:0] hi_s;

  always_comb begin
    fx_s  = $signed({2'b00, frog_x_i});
    lo_s  = $signed({2'b00, car_x_i}) - MARGIN_S;
    hi_s  = $signed({2'b00, car_x_i}) + REACH_HI;
    hit_o = y_eq && (fx_s >= lo_s) && (fx_s <= hi_s);
  end
`endif

endmodule

// File: rtl/collision_scanner.sv
// -----------------------------------------------------------------------------
// collision_scanner
//   Snapshots the frog and all N_CARS car positions on an accepted check
//   request, compares one car per clock, then tests the goal-row wall mask and
//   reports a registered result.  A reported hit opens a grace window of
//   GRACE_TICKS i_Tick pulses during which further hits are reported as
//   suppressed.  Reported hits are counted (saturating at 255).
//
//   Build option COLLISION_WRAP_EN (see car_span_cmp): car spans wrap modulo
//   GRID_W.  Wall logic is the same in both builds.
//
//   Ports:
//     i_Clk     : system clock
//     i_Reset   : asynchronous active-high reset
//     bus       : collision_scanner_if.slave
//                 in : i_Check, i_Tick, i_Frog_X/Y, i_Car_X/Y
//                 out: o_Busy, o_Done, o_Hit, o_Hit_Type, o_Hit_Idx,
//                      o_In_Grace, o_Hit_Count
//
//   Timing: o_Done pulses N_CARS+2 clocks after the edge that accepts
//   i_Check; o_Busy covers the cycle after acceptance through o_Done.
// -----------------------------------------------------------------------------
module collision_scanner
  import collision_pkg::*;
#(
  parameter int                N_CARS      = 5,
  parameter int                COORD_W     = 6,
  parameter int                CAR_LEN     = 1,
  parameter int                MARGIN      = 1,
  parameter int                GRID_W      = 20,
  parameter int                GOAL_ROW    = 0,
  parameter logic [GRID_W-1:0] WALL_MASK   = GRID_W'(DEFAULT_WALL_MASK),
  parameter int                GRACE_TICKS = 8
) (
  input  logic          i_Clk,
  input  logic          i_Reset,
  collision_scanner_if.slave bus
);

  localparam logic [3:0] LAST_IDX = 4'(N_CARS - 1);
  localparam int         GW       = (GRACE_TICKS < 2) ? 1 : $clog2(GRACE_TICKS + 1);
  localparam logic [GW-1:0]      GRACE_LOAD = GW'(GRACE_TICKS);
  localparam logic [COORD_W-1:0] GOAL_Y     = COORD_W'(GOAL_ROW);
  localparam logic [COORD_W:0]   GRID_X     = (COORD_W + 1)'(GRID_W);

  if (N_CARS < 1 || N_CARS > 16) begin : g_bad_ncars
    $error("collision_scanner: N_CARS must be in 1 .. 16");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                    state_q, state_d;
  logic [COORD_W-1:0]        frog_x_q, frog_y_q;
  logic [N_CARS*COORD_W-1:0] car_x_q, car_y_q;
  logic [3:0]                idx_q;
  logic                      found_q;
  logic [3:0]                found_idx_q;
  logic                      wall_q;
  logic                      done_q, done_d;
  result_t                   res_q, res_d;
  logic [7:0]                count_q, count_d;
  logic [GW-1:0]             grace_q, grace_d;

  // o_Done is registered, so the controller is already back in IDLE during
  // the o_Done cycle; done_q keeps that cycle busy so a check there is ignored.
  logic accept;
  assign accept = (state_q == IDLE) && !done_q && bus.i_Check;

  // ---------------------------------------------------------------------------
  // Snapshot unpacking and car selection.  Padded to 16 entries so the 4-bit
  // scan index always addresses a driven element.
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] car_x_arr [16];
  logic [COORD_W-1:0] car_y_arr [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
    if (gi < N_CARS) begin : g_car
      assign car_x_arr[gi] = car_x_q[gi*COORD_W +: COORD_W];
      assign car_y_arr[gi] = car_y_q[gi*COORD_W +: COORD_W];
    end else begin : g_pad
      assign car_x_arr[gi] = '0;
      assign car_y_arr[gi] = '0;
    end
  end

  logic car_hit;

  car_span_cmp #(
    .COORD_W (COORD_W),
    .CAR_LEN (CAR_LEN),
    .MARGIN  (MARGIN),
    .GRID_W  (GRID_W)
  ) u_cmp (
    .frog_x_i (frog_x_q),
    .frog_y_i (frog_y_q),
    .car_x_i  (car_x_arr[idx_q]),
    .car_y_i  (car_y_arr[idx_q]),
    .hit_o    (car_hit)
  );

  // ---------------------------------------------------------------------------
  // Goal-row wall test.  Columns past the playfield edge count as wall.
  // ---------------------------------------------------------------------------
  logic wall_bit;
  logic wall_cond;

  assign wall_bit  = |(WALL_MASK & (GRID_W'(1) << frog_x_q));
  assign wall_cond = (frog_y_q == GOAL_Y) &&
                     (({1'b0, frog_x_q} >= GRID_X) || wall_bit);

  logic       raw_hit;
  logic [1:0] raw_type;
  assign raw_hit  = found_q || wall_q;
  assign raw_type = found_q ? HIT_CAR : HIT_WALL;

  // ---------------------------------------------------------------------------
  // FSM next state, result, hit counter and grace counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    count_d = count_q;
    grace_d = grace_q;
    done_d  = 1'b0;

    if (bus.i_Tick && (grace_q != '0)) begin
      grace_d = grace_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == LAST_IDX) begin
          state_d = WALL;
        end
      end
      WALL: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!raw_hit) begin
          res_d = '{1'b0, HIT_NONE, 4'd0};
        end else if (grace_q == '0) begin
          res_d   = '{1'b1, raw_type, found_idx_q};
          // Overrides any same-cycle tick decrement above.
          grace_d = GRACE_LOAD;
          if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
        end else begin
          res_d = '{1'b0, HIT_SUPPRESSED, found_idx_q};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      res_q   <= '0;
      count_q <= '0;
      grace_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      res_q   <= res_d;
      count_q <= count_d;
      grace_q <= grace_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot and scan datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      frog_x_q    <= '0;
      frog_y_q    <= '0;
      car_x_q     <= '0;
      car_y_q     <= '0;
      idx_q       <= '0;
      found_q     <= 1'b0;
      found_idx_q <= '0;
      wall_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            frog_x_q    <= bus.i_Frog_X;
            frog_y_q    <= bus.i_Frog_Y;
            car_x_q     <= bus.i_Car_X;
            car_y_q     <= bus.i_Car_Y;
            idx_q       <= '0;
            found_q     <= 1'b0;
            found_idx_q <= '0;
            wall_q      <= 1'b0;
          end
        end
        SCAN: begin
          idx_q <= idx_q + 4'd1;
          // First hit sticks, so the lowest car index wins.
          if (car_hit && !found_q) begin
            found_q     <= 1'b1;
            found_idx_q <= idx_q;
          end
        end
        WALL: begin
          if (!found_q && wall_cond) begin
            wall_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.o_Busy      = (state_q != IDLE) || done_q;
  assign bus.o_Done      = done_q;
  assign bus.o_Hit       = res_q.hit;
  assign bus.o_Hit_Type  = res_q.hit_type;
  assign bus.o_Hit_Idx   = res_q.idx;
  assign bus.o_In_Grace  = (grace_q != '0);
  assign bus.o_Hit_Count = count_q;

endmodule

// File: tb/tb_collision_scanner.sv
// -----------------------------------------------------------------------------
// tb_collision_scanner
//   Directed bench for collision_scanner with default parameters.  Each check
//   request pushes its hand-computed expected result (including the cycle on
//   which o_Done must appear) into a scoreboard queue; a monitor pops and
//   compares on every o_Done pulse.  During each scan the live inputs are
//   rewritten to a configuration that would hit car 0, so any use of live
//   inputs instead of the snapshot shows up as a wrong result.
// -----------------------------------------------------------------------------
module tb_collision_scanner;

  localparam int N  = 5;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  collision_scanner_if #(.N_CARS(N), .COORD_W(CW)) bus ();

  collision_scanner #(.N_CARS(N), .COORD_W(CW)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  logic [CW-1:0] car_x [N];
  logic [CW-1:0] car_y [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign bus.i_Car_X[gi*CW +: CW] = car_x[gi];
    assign bus.i_Car_Y[gi*CW +: CW] = car_y[gi];
  end

  typedef struct {
    int         tag;
    logic       hit;
    logic [1:0] typ;
    logic [3:0] idx;
    logic [7:0] cnt;
    logic       grace;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks     = 0;
  int   errors     = 0;
  int   cyc        = 0;
  int   done_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare every o_Done pulse against the scoreboard head.
  always @(posedge clk) begin
    #1;
    if (bus.o_Done === 1'b1) begin
      done_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got o_Done=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        e = sb.pop_front();
        check_eq($sformatf("t%0d_done_cycle", e.tag), cyc, e.cyc);
        check_eq($sformatf("t%0d_hit", e.tag), {31'd0, bus.o_Hit}, {31'd0, e.hit});
        check_eq($sformatf("t%0d_type", e.tag), {30'd0, bus.o_Hit_Type}, {30'd0, e.typ});
        check_eq($sformatf("t%0d_idx", e.tag), {28'd0, bus.o_Hit_Idx}, {28'd0, e.idx});
        check_eq($sformatf("t%0d_count", e.tag), {24'd0, bus.o_Hit_Count}, {24'd0, e.cnt});
        check_eq($sformatf("t%0d_grace", e.tag), {31'd0, bus.o_In_Grace}, {31'd0, e.grace});
        $display("txn t%0d: hit=%0d type=%0d idx=%0d count=%0d grace=%0d", e.tag,
                 bus.o_Hit, bus.o_Hit_Type, bus.o_Hit_Idx, bus.o_Hit_Count, bus.o_In_Grace);
      end
    end
  end

  task automatic default_cars();
    for (int k = 0; k < N; k++) begin
      car_x[k] = CW'(30 + 2 * k);
      car_y[k] = CW'(10 + k);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.i_Tick = 1'b1;
    end
    @(negedge clk);
    bus.i_Tick = 1'b0;
  endtask

  // Issue one check and push its expected result.  If poke is set a second
  // i_Check is pulsed mid-scan; it must be ignored.
  task automatic do_check(input int tag, input logic [CW-1:0] fx, input logic [CW-1:0] fy,
                          input logic h, input logic [1:0] t, input logic [3:0] idx,
                          input logic [7:0] cnt, input logic g, input bit poke);
    logic [CW-1:0] sx [N];
    logic [CW-1:0] sy [N];
    exp_t ex;
    int   n;
    @(negedge clk);
    bus.i_Frog_X = fx;
    bus.i_Frog_Y = fy;
    bus.i_Check  = 1'b1;
    ex = '{tag: tag, hit: h, typ: t, idx: idx, cnt: cnt, grace: g, cyc: cyc + 8};
    sb.push_back(ex);
    @(negedge clk);
    bus.i_Check = 1'b0;
    check_eq($sformatf("t%0d_busy_in_scan", tag), {31'd0, bus.o_Busy}, 32'd1);
    for (int k = 0; k < N; k++) begin
      sx[k] = car_x[k];
      sy[k] = car_y[k];
      car_x[k] = fx;
      car_y[k] = fy;
    end
    if (poke) begin
      repeat (2) @(negedge clk);
      bus.i_Check = 1'b1;
      @(negedge clk);
      bus.i_Check = 1'b0;
    end
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL t%0d_timeout: got no o_Done within 40 cycles, expected one", tag);
      sb.delete();
    end
    for (int k = 0; k < N; k++) begin
      car_x[k] = sx[k];
      car_y[k] = sy[k];
    end
    @(negedge clk);
    check_eq($sformatf("t%0d_busy_after_done", tag), {31'd0, bus.o_Busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

  int done_before;

  initial begin
    bus.i_Check  = 1'b0;
    bus.i_Tick   = 1'b0;
    bus.i_Frog_X = '0;
    bus.i_Frog_Y = '0;
    default_cars();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy",  {31'd0, bus.o_Busy},       32'd0);
    check_eq("rst_done",  {31'd0, bus.o_Done},       32'd0);
    check_eq("rst_hit",   {31'd0, bus.o_Hit},        32'd0);
    check_eq("rst_type",  {30'd0, bus.o_Hit_Type},   32'd0);
    check_eq("rst_idx",   {28'd0, bus.o_Hit_Idx},    32'd0);
    check_eq("rst_grace", {31'd0, bus.o_In_Grace},   32'd0);
    check_eq("rst_count", {24'd0, bus.o_Hit_Count},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Car hit: car2 at (7,4) covers columns 6..8 of row 4
    car_x[2] = 6'd7; car_y[2] = 6'd4;
    do_check(1, 6'd8, 6'd4, 1'b1, 2'd1, 4'd2, 8'd1, 1'b1, 1'b0);

    // Grace: 3 ticks leave the window open, hit is suppressed
    ticks(3);
    do_check(2, 6'd8, 6'd4, 1'b0, 2'd3, 4'd2, 8'd1, 1'b1, 1'b0);
    ticks(5);
    #1;
    check_eq("grace_expired", {31'd0, bus.o_In_Grace}, 32'd0);
    do_check(3, 6'd8, 6'd4, 1'b1, 2'd1, 4'd2, 8'd2, 1'b1, 1'b0);
    ticks(8);
    default_cars();

    // Priority: cars 1 and 3 both on the frog, lowest index reported
    car_x[1] = 6'd10; car_y[1] = 6'd6;
    car_x[3] = 6'd10; car_y[3] = 6'd6;
    do_check(4, 6'd10, 6'd6, 1'b1, 2'd1, 4'd1, 8'd3, 1'b1, 1'b0);
    ticks(8);
    default_cars();

    // Goal row: column 3 wall, column 4 slot, column 25 off-grid wall
    do_check(5, 6'd3, 6'd0, 1'b1, 2'd2, 4'd0, 8'd4, 1'b1, 1'b0);
    ticks(8);
    do_check(6, 6'd4, 6'd0, 1'b0, 2'd0, 4'd0, 8'd4, 1'b0, 1'b0);
    do_check(7, 6'd25, 6'd0, 1'b1, 2'd2, 4'd0, 8'd5, 1'b1, 1'b0);
    ticks(8);

    // Busy: a second i_Check mid-scan is ignored, exactly one o_Done
    done_before = done_count;
    do_check(8, 6'd4, 6'd0, 1'b0, 2'd0, 4'd0, 8'd5, 1'b0, 1'b1);
    repeat (12) @(negedge clk);
    check_eq("busy_single_done", done_count - done_before, 32'd1);

    // Reset mid-scan: outputs clear at once, no o_Done follows
    car_x[2] = 6'd7; car_y[2] = 6'd4;
    @(negedge clk);
    bus.i_Frog_X = 6'd8;
    bus.i_Frog_Y = 6'd4;
    bus.i_Check  = 1'b1;
    @(negedge clk);
    bus.i_Check = 1'b0;
    repeat (2) @(negedge clk);
    done_before = done_count;
    rst = 1'b1;
    #1;
    check_eq("midrst_busy",  {31'd0, bus.o_Busy},      32'd0);
    check_eq("midrst_count", {24'd0, bus.o_Hit_Count}, 32'd0);
    check_eq("midrst_type",  {30'd0, bus.o_Hit_Type},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("midrst_no_done", done_count - done_before, 32'd0);

    // Normal scan after reset
    do_check(9, 6'd8, 6'd4, 1'b1, 2'd1, 4'd2, 8'd1, 1'b1, 1'b0);
    ticks(8);
    default_cars();

    // Left edge: car at 0 must not reach frog at 63
    car_x[0] = 6'd0; car_y[0] = 6'd5;
    do_check(10, 6'd63, 6'd5, 1'b0, 2'd0, 4'd0, 8'd1, 1'b0, 1'b0);

    // Right edge: car at 19 reaches column 0 only when wrapping
    car_x[0] = 6'd19; car_y[0] = 6'd5;
`ifdef COLLISION_WRAP_EN
    do_check(11, 6'd0, 6'd5, 1'b1, 2'd1, 4'd0, 8'd2, 1'b1, 1'b0);
`else
    do_check(11, 6'd0, 6'd5, 1'b0, 2'd0, 4'd0, 8'd1, 1'b0, 1'b0);
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
